packet_transmitter: RTL and testbench

Downstream stage of the data-capture block. It drains accumulated 16-bit histogram words from the capture block's transmit FIFO and frames them as byte packets for the UART transmitter: header, word count, data bytes MSB first, then checksum. It also drives `readyToTransmit` back to the capture block, so accumulated events are dumped only when a packet can be sent.

---
 rtl/packet_transmitter_pkg.sv | 29 ++
 rtl/packet_transmitter_if.sv | 30 +++
 rtl/packet_transmitter_tx_byte_issuer.sv | 48 ++++
 rtl/packet_transmitter.sv | 140 ++++++++++++++
 tb/tb_packet_transmitter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_transmitter_pkg.sv
// rtl/packet_transmitter_pkg.sv - shared constants and types for packet_transmitter
// Purpose: FSM state encoding (one-hot), default sync byte, checksum width and
//          the checksum accumulate helper.
// Ports:   none (package).
package packet_transmitter_pkg;

   localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
   localparam int         CSUM_W              = 8;
   localparam int         STATE_W             = 9;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE       = 9'b000000001,
      ST_HDR        = 9'b000000010,
      ST_CNT_HI     = 9'b000000100,
      ST_CNT_LO     = 9'b000001000,
      ST_FETCH      = 9'b000010000,
      ST_WAIT_VALID = 9'b000100000,
      ST_SEND_HI    = 9'b001000000,
      ST_SEND_LO    = 9'b010000000,
      ST_CSUM       = 9'b100000000
   } state_e;

   // Modulo-256 running sum; the carry is intentionally dropped.
   function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                  input logic [7:0]        b);
      return acc + b;
   endfunction

endpackage

// File: rtl/packet_transmitter_if.sv
// rtl/packet_transmitter_if.sv - FIFO-side and UART-side signals of packet_transmitter
// Purpose: groups the source-FIFO read handshake, the UART byte handshake and
//          the status outputs.
// Ports:   dataReadyToRead/dataValid/dataIn/dataRead  - source FIFO
//          txReady/txStrobe/txData                     - UART byte issue
//          readyToTransmit/packetActive                - status
// Modports: slave = the transmitter, master = its environment.
interface packet_transmitter_if;

   logic        dataReadyToRead;
   logic        dataValid;
   logic [15:0] dataIn;
   logic        dataRead;
   logic        readyToTransmit;
   logic        txReady;
   logic        txStrobe;
   logic [7:0]  txData;
   logic        packetActive;

   modport slave (
      input  dataReadyToRead, dataValid, dataIn, txReady,
      output dataRead, readyToTransmit, txStrobe, txData, packetActive
   );

   modport master (
      output dataReadyToRead, dataValid, dataIn, txReady,
      input  dataRead, readyToTransmit, txStrobe, txData, packetActive
   );

endinterface

// File: rtl/packet_transmitter_tx_byte_issuer.sv
// rtl/packet_transmitter_tx_byte_issuer.sv - UART byte handshake with guard cycle
// Purpose: turns a held byte request into a single registered strobe once the
//          UART is ready; the strobe itself acts as the guard cycle so two
//          strobes are always at least 2 cycles apart.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          req_i        - a byte is waiting to be sent
//          byte_i       - the byte to send
//          tx_ready_i   - UART can accept a byte
//          tx_strobe_o  - one-cycle registered issue pulse (doubles as "done")
//          tx_data_o    - registered byte, stable while tx_strobe_o is high
module packet_transmitter_tx_byte_issuer (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_i,
   input  logic [7:0] byte_i,
   input  logic       tx_ready_i,
   output logic       tx_strobe_o,
   output logic [7:0] tx_data_o
);

   logic       strobe_q, strobe_d;
   logic [7:0] data_q, data_d;

   always_comb begin
      strobe_d = 1'b0;
      data_d   = data_q;
      // Blocking on strobe_q gives the guard cycle: the requester advances
      // during the strobe cycle, so no stale request can issue twice.
      if (req_i && tx_ready_i && !strobe_q) begin
         strobe_d = 1'b1;
         data_d   = byte_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_q <= 1'b0;
         data_q   <= 8'h00;
      end else begin
         strobe_q <= strobe_d;
         data_q   <= data_d;
      end
   end

   assign tx_strobe_o = strobe_q;
   assign tx_data_o   = data_q;

endmodule

// File: rtl/packet_transmitter.sv
// rtl/packet_transmitter.sv - frames 16-bit FIFO words into UART byte packets
// Purpose: packet = HEADER_BYTE, count hi, count lo, data bytes MSB first,
//          modulo-256 checksum of count and data bytes.
// Ports:   clk  - clock
//          rst  - synchronous active-high reset
//          bus  - packet_transmitter_if.slave (FIFO read, UART issue, status)
module packet_transmitter
   import packet_transmitter_pkg::*;
#(
   parameter int         WORDS_PER_PACKET = 128,
   parameter logic [7:0] HEADER_BYTE      = HEADER_BYTE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   packet_transmitter_if.slave  bus
);

   localparam logic [15:0] WPP      = 16'(WORDS_PER_PACKET);
   localparam logic [15:0] WPP_LAST = WPP - 16'd1;

   state_e              state_q, state_d;
   logic [15:0]         word_cnt_q, word_cnt_d;
   logic [CSUM_W-1:0]   csum_q, csum_d;
   logic [15:0]         word_q, word_d;
   logic                data_read_q, data_read_d;

   logic                issue_req;
   logic [7:0]          issue_byte;
   logic                tx_strobe;
   logic [7:0]          tx_data;

   packet_transmitter_tx_byte_issuer u_issuer (
      .clk         (clk),
      .rst         (rst),
      .req_i       (issue_req),
      .byte_i      (issue_byte),
      .tx_ready_i  (bus.txReady),
      .tx_strobe_o (tx_strobe),
      .tx_data_o   (tx_data)
   );

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      csum_d      = csum_q;
      word_d      = word_q;
      issue_req   = 1'b0;
      issue_byte  = 8'h00;

      // Accumulate on the strobe of every count and data byte.
      if (tx_strobe && (state_q == ST_CNT_HI || state_q == ST_CNT_LO ||
                        state_q == ST_SEND_HI || state_q == ST_SEND_LO)) begin
         csum_d = csum_add(csum_q, tx_data);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.dataReadyToRead) begin
               state_d    = ST_HDR;
               word_cnt_d = 16'd0;
               csum_d     = '0;
            end
         end
         ST_HDR: begin
            issue_req  = 1'b1;
            issue_byte = HEADER_BYTE;
            if (tx_strobe) state_d = ST_CNT_HI;
         end
         ST_CNT_HI: begin
            issue_req  = 1'b1;
            issue_byte = WPP[15:8];
            if (tx_strobe) state_d = ST_CNT_LO;
         end
         ST_CNT_LO: begin
            issue_req  = 1'b1;
            issue_byte = WPP[7:0];
            if (tx_strobe) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // The read pulse was registered on the way in (see data_read_d),
            // so it is visible during this cycle and the data follows next.
            if (data_read_q) state_d = ST_WAIT_VALID;
         end
         ST_WAIT_VALID: begin
            if (bus.dataValid) begin
               word_d  = bus.dataIn;
               state_d = ST_SEND_HI;
            end
         end
         ST_SEND_HI: begin
            issue_req  = 1'b1;
            issue_byte = word_q[15:8];
            if (tx_strobe) state_d = ST_SEND_LO;
         end
         ST_SEND_LO: begin
            issue_req  = 1'b1;
            issue_byte = word_q[7:0];
            if (tx_strobe) begin
               // Compare before incrementing so the counter never wraps.
               state_d    = (word_cnt_q == WPP_LAST) ? ST_CSUM : ST_FETCH;
               word_cnt_d = word_cnt_q + 16'd1;
            end
         end
         ST_CSUM: begin
            issue_req  = 1'b1;
            issue_byte = csum_q;
            if (tx_strobe) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Issue the read as FETCH is entered (or while stalled in it), so
      // the pulse lands in the FETCH cycle and dataValid in WAIT_VALID.
      // A pending read moves FETCH on, so no second read is ever issued.
      data_read_d = (state_d == ST_FETCH) && bus.dataReadyToRead;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         word_cnt_q  <= 16'd0;
         csum_q      <= '0;
         word_q      <= 16'd0;
         data_read_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         csum_q      <= csum_d;
         word_q      <= word_d;
         data_read_q <= data_read_d;
      end
   end

   assign bus.dataRead        = data_read_q;
   assign bus.txStrobe        = tx_strobe;
   assign bus.txData          = tx_data;
   assign bus.readyToTransmit = (state_q == ST_IDLE) && !rst;
   assign bus.packetActive    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_packet_transmitter.sv
// tb/tb_packet_transmitter.sv - self-checking bench for packet_transmitter
module tb_packet_transmitter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   packet_transmitter_if if_s ();
   packet_transmitter_if if_l ();

   packet_transmitter #(.WORDS_PER_PACKET(2)) u_small (
      .clk (clk), .rst (rst), .bus (if_s.slave)
   );
   packet_transmitter u_large (
      .clk (clk), .rst (rst), .bus (if_l.slave)
   );

   // Environment state
   logic        sel = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   int          tx_mode = 0;
   logic        tx_ready = 1'b1;
   logic [15:0] mem [0:511];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic        fifo_valid = 1'b0;
   logic [15:0] fifo_data = 16'h0000;
   logic        fifo_ne;

   logic        mon_strobe, mon_read, mon_active;
   logic [7:0]  mon_data;

   assign fifo_ne    = (wr_ptr != rd_ptr) && !hold;
   assign mon_strobe = sel ? if_l.txStrobe     : if_s.txStrobe;
   assign mon_data   = sel ? if_l.txData       : if_s.txData;
   assign mon_read   = sel ? if_l.dataRead     : if_s.dataRead;
   assign mon_active = sel ? if_l.packetActive : if_s.packetActive;

   assign if_s.dataReadyToRead = !sel && fifo_ne;
   assign if_l.dataReadyToRead = sel && fifo_ne;
   assign if_s.dataValid = fifo_valid;
   assign if_l.dataValid = fifo_valid;
   assign if_s.dataIn    = fifo_data;
   assign if_l.dataIn    = fifo_data;
   assign if_s.txReady   = tx_ready;
   assign if_l.txReady   = tx_ready;

   // Source FIFO: data valid one cycle after the read pulse.
   always @(posedge clk) begin
      fifo_valid <= 1'b0;
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (mon_read && rd_ptr != wr_ptr) begin
         fifo_valid <= 1'b1;
         fifo_data  <= mem[rd_ptr % 512];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   // UART readiness: always, 1-high/5-low, or random.
   always @(negedge clk) begin
      case (tx_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = (cyc % 6 == 0);
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic ready_at_edge = 1'b0;
   always @(posedge clk) ready_at_edge <= tx_ready;

   // Byte monitor
   logic [7:0] rx_q[$];
   int         rx_cyc[$];
   int         viol_ready = 0;
   int         viol_gap = 0;
   int         n_reads = 0;
   int         prev_cyc = -100;
   logic       active_at_strobe = 1'b0;

   always @(negedge clk) begin
      if (mon_strobe) begin
         rx_q.push_back(mon_data);
         rx_cyc.push_back(cyc);
         if (!ready_at_edge) viol_ready++;
         if (cyc - prev_cyc < 2) viol_gap++;
         prev_cyc = cyc;
         active_at_strobe = mon_active;
      end
      if (mon_read) n_reads++;
   end

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q[$];

   // Reference packet built directly from the framing rules.
   function automatic void model_append(input logic [15:0] w[$], input int wpp);
      int sum;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(wpp >> 8));
      exp_q.push_back(8'(wpp & 255));
      sum = (wpp >> 8) + (wpp & 255);
      foreach (w[i]) begin
         exp_q.push_back(w[i][15:8]);
         exp_q.push_back(w[i][7:0]);
         sum = sum + int'(w[i][15:8]) + int'(w[i][7:0]);
      end
      exp_q.push_back(8'(sum % 256));
   endfunction

   task automatic push_word(input logic [15:0] w);
      mem[wr_ptr % 512] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_bytes(input int target, input int budget, output bit ok);
      int n;
      n = 0;
      while (rx_q.size() < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      ok = (rx_q.size() >= target);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (if_s.readyToTransmit !== 1'b0) begin fails++; $display("FAIL reset_rtt got %b expected 0", if_s.readyToTransmit); end
      tests++; if (if_s.txStrobe !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b expected 0", if_s.txStrobe); end
      tests++; if (if_s.txData !== 8'h00) begin fails++; $display("FAIL reset_txdata got %h expected 00", if_s.txData); end
      tests++; if (if_s.dataRead !== 1'b0) begin fails++; $display("FAIL reset_read got %b expected 0", if_s.dataRead); end
      tests++; if (if_s.packetActive !== 1'b0) begin fails++; $display("FAIL reset_active got %b expected 0", if_s.packetActive); end
      tests++; if (if_l.readyToTransmit !== 1'b0) begin fails++; $display("FAIL reset_rtt_l got %b expected 0", if_l.readyToTransmit); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      tests++; if (if_s.readyToTransmit !== 1'b1) begin fails++; $display("FAIL release_rtt got %b expected 1", if_s.readyToTransmit); end
      tests++; if (if_l.readyToTransmit !== 1'b1) begin fails++; $display("FAIL release_rtt_l got %b expected 1", if_l.readyToTransmit); end
   endtask

   task automatic test_basic();
      logic [15:0] w[$];
      int base, rd0, t0;
      bit ok;
      base = rx_q.size(); rd0 = n_reads;
      w = {16'h1234, 16'hABCD};
      exp_q.delete(); model_append(w, 2);
      @(negedge clk); t0 = cyc;
      foreach (w[i]) push_word(w[i]);
      wait_bytes(base + 8, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got %0d bytes expected 8", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL basic_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
      if (ok) begin
         tests++; if (rx_cyc[base] - t0 !== 2) begin fails++; $display("FAIL basic_first_latency got %0d expected 2", rx_cyc[base] - t0); end
         tests++; if (rx_cyc[base + 3] - rx_cyc[base + 2] !== 4) begin fails++; $display("FAIL basic_cnt_to_data got %0d expected 4", rx_cyc[base + 3] - rx_cyc[base + 2]); end
         tests++; if (rx_cyc[base + 6] - rx_cyc[base + 4] !== 6) begin fails++; $display("FAIL basic_word_period got %0d expected 6", rx_cyc[base + 6] - rx_cyc[base + 4]); end
         tests++; if (rx_cyc[base + 7] - rx_cyc[base + 6] !== 2) begin fails++; $display("FAIL basic_csum_gap got %0d expected 2", rx_cyc[base + 7] - rx_cyc[base + 6]); end
      end
      tests++; if (active_at_strobe !== 1'b1) begin fails++; $display("FAIL basic_active_at_csum got %b expected 1", active_at_strobe); end
      tests++; if (if_s.packetActive !== 1'b0) begin fails++; $display("FAIL basic_active_after got %b expected 0", if_s.packetActive); end
      tests++; if (n_reads - rd0 !== 2) begin fails++; $display("FAIL basic_reads got %0d expected 2", n_reads - rd0); end
   endtask

   task automatic test_backpressure();
      logic [15:0] w[$];
      int base, vr0, vg0;
      bit ok;
      base = rx_q.size(); vr0 = viol_ready; vg0 = viol_gap;
      w = {16'h1234, 16'hABCD};
      exp_q.delete(); model_append(w, 2);
      @(negedge clk); tx_mode = 1;
      foreach (w[i]) push_word(w[i]);
      wait_bytes(base + 8, 600, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bp_timeout got %0d bytes expected 8", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL bp_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
      tests++; if (viol_ready !== vr0) begin fails++; $display("FAIL bp_strobe_without_ready got %0d expected %0d", viol_ready, vr0); end
      tests++; if (viol_gap !== vg0) begin fails++; $display("FAIL bp_strobe_gap got %0d expected %0d", viol_gap, vg0); end
      @(negedge clk); tx_mode = 0;
   endtask

   task automatic test_underrun();
      logic [15:0] w[$];
      int base, rd0;
      bit ok;
      base = rx_q.size();
      w = {16'($urandom), 16'($urandom)};
      exp_q.delete(); model_append(w, 2);
      @(negedge clk); push_word(w[0]);
      wait_bytes(base + 5, 200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL underrun_first_word got %0d bytes expected 5", rx_q.size() - base); end
      @(negedge clk); hold = 1'b1; push_word(w[1]); rd0 = n_reads;
      repeat (20) @(negedge clk);
      tests++; if (n_reads !== rd0) begin fails++; $display("FAIL underrun_read_during_stall got %0d expected %0d", n_reads, rd0); end
      tests++; if (rx_q.size() - base !== 5) begin fails++; $display("FAIL underrun_bytes_during_stall got %0d expected 5", rx_q.size() - base); end
      tests++; if (if_s.packetActive !== 1'b1) begin fails++; $display("FAIL underrun_active got %b expected 1", if_s.packetActive); end
      hold = 1'b0;
      wait_bytes(base + 8, 200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL underrun_timeout got %0d bytes expected 8", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL underrun_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] w[$];
      int base;
      bit ok;
      base = rx_q.size();
      w = {16'($urandom), 16'($urandom)};
      @(negedge clk); foreach (w[i]) push_word(w[i]);
      wait_bytes(base + 4, 200, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rstmid_prefix got %0d bytes expected 4", rx_q.size() - base); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (if_s.txStrobe !== 1'b0) begin fails++; $display("FAIL rstmid_strobe got %b expected 0", if_s.txStrobe); end
      tests++; if (if_s.readyToTransmit !== 1'b0) begin fails++; $display("FAIL rstmid_rtt got %b expected 0", if_s.readyToTransmit); end
      tests++; if (if_s.packetActive !== 1'b0) begin fails++; $display("FAIL rstmid_active got %b expected 0", if_s.packetActive); end
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      tests++; if (rx_q.size() - base !== 4) begin fails++; $display("FAIL rstmid_no_csum got %0d bytes expected 4", rx_q.size() - base); end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++; if (if_s.readyToTransmit !== 1'b1) begin fails++; $display("FAIL rstmid_rtt_release got %b expected 1", if_s.readyToTransmit); end
      base = rx_q.size();
      w = {16'($urandom), 16'($urandom)};
      exp_q.delete(); model_append(w, 2);
      @(negedge clk); foreach (w[i]) push_word(w[i]);
      wait_bytes(base + 8, 300, ok);
      tests++; if (!ok) begin fails++; $display("FAIL rstmid_timeout got %0d bytes expected 8", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL rstmid_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w[$];
      int base, rd0, vr0, vg0;
      bit ok;
      base = rx_q.size(); rd0 = n_reads; vr0 = viol_ready; vg0 = viol_gap;
      exp_q.delete();
      @(negedge clk); tx_mode = 2;
      for (int p = 0; p < 3; p++) begin
         w = {16'($urandom), 16'($urandom)};
         model_append(w, 2);
         foreach (w[i]) push_word(w[i]);
      end
      wait_bytes(base + 24, 2000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d bytes expected 24", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL b2b_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
      tests++; if (viol_ready !== vr0) begin fails++; $display("FAIL b2b_strobe_without_ready got %0d expected %0d", viol_ready, vr0); end
      tests++; if (viol_gap !== vg0) begin fails++; $display("FAIL b2b_strobe_gap got %0d expected %0d", viol_gap, vg0); end
      tests++; if (n_reads - rd0 !== 6) begin fails++; $display("FAIL b2b_reads got %0d expected 6", n_reads - rd0); end
      @(negedge clk); tx_mode = 0;
   endtask

   task automatic test_default_size();
      logic [15:0] w[$];
      int base, rd0;
      bit ok;
      repeat (4) @(negedge clk);
      sel = 1'b1;
      base = rx_q.size(); rd0 = n_reads;
      w.delete();
      for (int i = 0; i < 128; i++) w.push_back(16'(i));
      exp_q.delete(); model_append(w, 128);
      foreach (w[i]) push_word(w[i]);
      wait_bytes(base + 260, 3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL dflt_timeout got %0d bytes expected 260", rx_q.size() - base); end
      repeat (10) @(posedge clk);
      #1;
      tests++; if (rx_q.size() - base !== 260) begin fails++; $display("FAIL dflt_length got %0d expected 260", rx_q.size() - base); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
            fails++; $display("FAIL dflt_byte[%0d] got %h expected %h", i, (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx, exp_q[i]);
         end
      end
      tests++; if (n_reads - rd0 !== 128) begin fails++; $display("FAIL dflt_reads got %0d expected 128", n_reads - rd0); end
      tests++; if (if_l.packetActive !== 1'b0) begin fails++; $display("FAIL dflt_active_after got %b expected 0", if_l.packetActive); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_underrun();
      test_reset_mid();
      test_back_to_back();
      test_default_size();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
